// File: rtl/ps2_entry_pkg.sv
// Shared scan codes, FSM state type and scan-code decoding for the PS/2
// numeric entry block.
package ps2_entry_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } digit_t;

  function automatic digit_t scan_to_digit(input logic [7:0] code);
    digit_t d;
    d.vld = 1'b1;
    case (code)
      SC_0:    d.val = 4'd0;
      SC_1:    d.val = 4'd1;
      SC_2:    d.val = 4'd2;
      SC_3:    d.val = 4'd3;
      SC_4:    d.val = 4'd4;
      SC_5:    d.val = 4'd5;
      SC_6:    d.val = 4'd6;
      SC_7:    d.val = 4'd7;
      SC_8:    d.val = 4'd8;
      SC_9:    d.val = 4'd9;
      default: begin
        d.vld = 1'b0;
        d.val = 4'd0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Registers incoming PS/2 bytes and passes on only make codes: the byte after
// F0 is swallowed as a break code and E0 prefixes are dropped on their own.
module ps2_make_filter
  import ps2_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_data,
  input  logic       key_pressed,
  output logic       make_strobe,
  output logic [7:0] make_code
);

  logic       brk_q, brk_d;
  logic       strobe_q, strobe_d;
  logic [7:0] code_q, code_d;

  always_comb begin
    brk_d    = brk_q;
    strobe_d = 1'b0;
    code_d   = code_q;
    if (key_pressed) begin
      if (key_data == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (key_data == SC_EXT) begin
        brk_d = brk_q;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else begin
        strobe_d = 1'b1;
        code_d   = key_data;
      end
    end
  end

  // filter register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q    <= 1'b0;
      strobe_q <= 1'b0;
      code_q   <= 8'h00;
    end else begin
      brk_q    <= brk_d;
      strobe_q <= strobe_d;
      code_q   <= code_d;
    end
  end

  assign make_strobe = strobe_q;
  assign make_code   = code_q;

endmodule

// File: rtl/ps2_multi_param_entry.sv
// Multi-channel keyboard numeric entry: collects decimal digits from PS/2 make
// codes, clamps the result and stores it in the selected channel slot.
module ps2_multi_param_entry
  import ps2_entry_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIGITS      = 3,
  parameter int MAX_VAL     = 100,
  parameter int VAL_W       = 7,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ps2_key_data,
  input  logic                    ps2_key_pressed,
  input  logic [NUM_CH-1:0]       chan_on,
  input  logic [NUM_CH-1:0]       chan_set,
  output logic [NUM_CH-1:0]       active_ch,
  output logic                    busy,
  output logic [2:0]              digit_count,
  output logic [NUM_CH*VAL_W-1:0] chan_values,
  output logic                    commit_valid,
  output logic                    abort_pulse
);

  localparam int BW = 4 * DIGITS;
  localparam int AW = $clog2(10 ** DIGITS);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  function automatic logic [AW-1:0] bcd_to_bin(input logic [BW-1:0] b);
    logic [AW-1:0] acc;
    acc = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc = acc * AW'(10) + AW'(b[4*k +: 4]);
    end
    return acc;
  endfunction

  function automatic logic [VAL_W-1:0] clamp_val(input logic [AW-1:0] v);
    if (32'(v) > 32'(MAX_VAL)) return VAL_W'(MAX_VAL);
    return VAL_W'(v);
  endfunction

  logic       make_strobe;
  logic [7:0] make_code;

  ps2_make_filter u_filter (
    .clk         (clk),
    .rst         (rst),
    .key_data    (ps2_key_data),
    .key_pressed (ps2_key_pressed),
    .make_strobe (make_strobe),
    .make_code   (make_code)
  );

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0]             active_q, active_d;
  logic [BW-1:0]                 bcd_q, bcd_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [TW-1:0]                 tmr_q, tmr_d;
  logic [NUM_CH-1:0][VAL_W-1:0]  vals_q, vals_d;
  logic                          commit_q, commit_d;
  logic                          abort_q, abort_d;
  logic [NUM_CH-1:0]             sel;
  logic [VAL_W-1:0]              new_val;
  logic                          do_abort;
  digit_t                        dig;

  assign dig     = scan_to_digit(make_code);
  assign new_val = clamp_val(bcd_to_bin(bcd_q));

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    vals_d   = vals_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    do_abort = 1'b0;
    sel      = '0;
    // descending scan so the lowest requesting channel wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_set[i] && chan_on[i]) sel = NUM_CH'(1) << i;
    end
    case (state_q)
      IDLE: begin
        if (|sel) begin
          state_d  = ENTRY;
          active_d = sel;
          bcd_d    = '0;
          cnt_d    = 3'd0;
          tmr_d    = '0;
        end
      end
      ENTRY: begin
        if (!(|(chan_on & active_q))) begin
          do_abort = 1'b1;
        end else if (make_strobe) begin
          tmr_d = '0;
          if (dig.vld) begin
            if (cnt_q < 3'(DIGITS)) begin
              bcd_d = (bcd_q << 4) | BW'(dig.val);
              cnt_d = cnt_q + 3'd1;
            end
          end else if (make_code == SC_BKSP) begin
            if (cnt_q != 3'd0) begin
              bcd_d = bcd_q >> 4;
              cnt_d = cnt_q - 3'd1;
            end
          end else if (make_code == SC_ENTER) begin
            if (cnt_q != 3'd0) begin
              state_d  = COMMIT;
              commit_d = 1'b1;
              for (int i = 0; i < NUM_CH; i++) begin
                if (active_q[i]) vals_d[i] = new_val;
              end
            end
          end else if (make_code == SC_ESC) begin
            do_abort = 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (tmr_q == T_LAST) do_abort = 1'b1;
          else                 tmr_d    = tmr_q + TW'(1);
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        active_d = '0;
        bcd_d    = '0;
        cnt_d    = 3'd0;
      end
      default: state_d = IDLE;
    endcase
    if (do_abort) begin
      state_d  = IDLE;
      active_d = '0;
      bcd_d    = '0;
      cnt_d    = 3'd0;
      abort_d  = 1'b1;
    end
  end

  // control and value register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      bcd_q    <= '0;
      cnt_q    <= 3'd0;
      tmr_q    <= '0;
      vals_q   <= '0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      vals_q   <= vals_d;
      commit_q <= commit_d;
      abort_q  <= abort_d;
    end
  end

  assign active_ch    = active_q;
  assign busy         = (state_q != IDLE);
  assign digit_count  = cnt_q;
  assign chan_values  = vals_q;
  assign commit_valid = commit_q;
  assign abort_pulse  = abort_q;

endmodule

// File: tb/tb_ps2_multi_param_entry.sv
// Bench for ps2_multi_param_entry: directed key sequences, a cycle-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_ps2_multi_param_entry;

  localparam int NUM_CH  = 3;
  localparam int DIGITS  = 3;
  localparam int MAX_VAL = 100;
  localparam int VAL_W   = 7;
  localparam int TOUT    = 20;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [7:0]              ps2_key_data = 8'h00;
  logic                    ps2_key_pressed = 1'b0;
  logic [NUM_CH-1:0]       chan_on = '0;
  logic [NUM_CH-1:0]       chan_set = '0;
  logic [NUM_CH-1:0]       active_ch;
  logic                    busy;
  logic [2:0]              digit_count;
  logic [NUM_CH*VAL_W-1:0] chan_values;
  logic                    commit_valid;
  logic                    abort_pulse;

  int checks   = 0;
  int failures = 0;
  int n_abort  = 0;
  int n_commit = 0;

  ps2_multi_param_entry #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL),
    .VAL_W(VAL_W), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .chan_on         (chan_on),
    .chan_set        (chan_set),
    .active_ch       (active_ch),
    .busy            (busy),
    .digit_count     (digit_count),
    .chan_values     (chan_values),
    .commit_valid    (commit_valid),
    .abort_pulse     (abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: digits kept in a queue, value computed with integer arithmetic
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int m_mode = 0;  // 0 idle, 1 entering digits, 2 commit cycle
  int m_ch   = 0;
  int m_q[$];
  int m_idle = 0;
  int m_vals [NUM_CH] = '{0, 0, 0};
  bit m_commit = 0, m_abort = 0, m_brk = 0, m_stb = 0;
  logic [7:0] m_code = 8'h00;

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == c) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit stop;
    bit found;
    int d;
    int v;
    if (rst) begin
      m_mode = 0; m_ch = 0; m_q.delete(); m_idle = 0;
      m_commit = 0; m_abort = 0; m_brk = 0; m_stb = 0; m_code = 8'h00;
      for (int i = 0; i < NUM_CH; i++) m_vals[i] = 0;
    end else begin
      stop = 0; m_commit = 0; m_abort = 0;
      if (m_mode == 0) begin
        found = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && chan_set[i] && chan_on[i]) begin
            found = 1; m_ch = i;
          end
        end
        if (found) begin
          m_mode = 1; m_q.delete(); m_idle = 0;
        end
      end else if (m_mode == 1) begin
        if (!chan_on[m_ch]) stop = 1;
        else if (m_stb) begin
          m_idle = 0;
          d = digit_of(m_code);
          if (d >= 0) begin
            if (m_q.size() < DIGITS) m_q.push_back(d);
          end else if (m_code == 8'h66) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
          end else if (m_code == 8'h5A) begin
            if (m_q.size() > 0) begin
              v = 0;
              foreach (m_q[k]) v = v * 10 + m_q[k];
              if (v > MAX_VAL) v = MAX_VAL;
              m_vals[m_ch] = v;
              m_commit = 1;
              m_mode = 2;
            end
          end else if (m_code == 8'h76) stop = 1;
        end else begin
          m_idle++;
          if (m_idle >= TOUT) stop = 1;
        end
      end else begin
        m_mode = 0; m_q.delete();
      end
      if (stop) begin
        m_mode = 0; m_abort = 1; m_q.delete();
      end
      m_stb = 0;
      if (ps2_key_pressed) begin
        if (ps2_key_data == 8'hF0) m_brk = 1;
        else if (ps2_key_data == 8'hE0) m_brk = m_brk;
        else if (m_brk) m_brk = 0;
        else begin
          m_stb = 1; m_code = ps2_key_data;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [NUM_CH*VAL_W-1:0] exp_vals;
    logic [NUM_CH-1:0]       exp_act;
    for (int i = 0; i < NUM_CH; i++) exp_vals[i*VAL_W +: VAL_W] = VAL_W'(m_vals[i]);
    exp_act = (m_mode != 0) ? NUM_CH'(1) << m_ch : '0;
    chk("cyc_active_ch", 32'(active_ch), 32'(exp_act));
    chk("cyc_busy", 32'(busy), 32'(m_mode != 0));
    chk("cyc_digit_count", 32'(digit_count), 32'(m_q.size()));
    chk("cyc_chan_values", 32'(chan_values), 32'(exp_vals));
    chk("cyc_commit_valid", 32'(commit_valid), 32'(m_commit));
    chk("cyc_abort_pulse", 32'(abort_pulse), 32'(m_abort));
    if (abort_pulse === 1'b1) n_abort++;
    if (commit_valid === 1'b1) n_commit++;
  end

  task automatic key(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clk);
    ps2_key_pressed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic select(input logic [NUM_CH-1:0] s);
    chan_set = s;
    @(negedge clk);
    chan_set = '0;
  endtask

  function automatic int slot(input int i);
    return int'(chan_values[i*VAL_W +: VAL_W]);
  endfunction

  initial begin : stim
    int a0;
    int c0;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_values", 32'(chan_values), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_active", 32'(active_ch), 32'd0);
    chan_on = 3'b111;

    // 1,0,0 -> clamp ... 100 fits exactly; commit latency of 2 cycles after Enter
    select(3'b010);
    chk("sel_ch1", 32'(active_ch), 32'b010);
    key(8'h16); key(8'h45); key(8'h45);
    ps2_key_data = 8'h5A; ps2_key_pressed = 1'b1;
    @(negedge clk); ps2_key_pressed = 1'b0;
    chk("enter_lat1", 32'(commit_valid), 32'd0);
    @(negedge clk);
    chk("enter_lat2", 32'(commit_valid), 32'd1);
    chk("ch1_value_100", 32'(slot(1)), 32'd100);
    @(negedge clk);
    chk("commit_one_cycle", 32'(commit_valid), 32'd0);
    @(negedge clk);

    // break code ignored: 5, F0 5, 4 -> 54
    select(3'b001);
    key(8'h2E); key(8'hF0); key(8'h2E); key(8'h25); key(8'h5A);
    chk("ch0_value_54", 32'(slot(0)), 32'd54);

    // backspace drops 9, extended Enter (E0 5A) -> 37
    select(3'b100);
    key(8'h26); key(8'h3D); key(8'h46); key(8'h66);
    chk("bksp_count", 32'(digit_count), 32'd2);
    key(8'hE0); key(8'h5A);
    chk("ch2_value_37", 32'(slot(2)), 32'd37);

    // fourth digit ignored: 0,0,5,(7) -> 5
    select(3'b001);
    key(8'h45); key(8'h45); key(8'h2E); key(8'h3D);
    chk("four_digit_count", 32'(digit_count), 32'd3);
    key(8'h5A);
    chk("ch0_value_5", 32'(slot(0)), 32'd5);

    // Esc aborts, slot unchanged
    a0 = n_abort;
    select(3'b100);
    key(8'h16); key(8'h76);
    chk("esc_abort_seen", 32'(n_abort - a0), 32'd1);
    chk("esc_slot_held", 32'(slot(2)), 32'd37);
    chk("esc_idle", 32'(busy), 32'd0);

    // channel-off abort wins over a coincident Enter
    c0 = n_commit;
    select(3'b010);
    key(8'h1E);
    ps2_key_data = 8'h5A; ps2_key_pressed = 1'b1;
    @(negedge clk); ps2_key_pressed = 1'b0; chan_on = 3'b101;
    @(negedge clk);
    chk("off_abort_pulse", 32'(abort_pulse), 32'd1);
    chk("off_no_commit", 32'(n_commit - c0), 32'd0);
    chan_on = 3'b111;
    repeat (2) @(negedge clk);
    chk("off_slot_held", 32'(slot(1)), 32'd100);

    // simultaneous requests: lowest enabled channel wins
    select(3'b110);
    chk("multi_sel_ch1", 32'(active_ch), 32'b010);
    key(8'h76);

    // idle timeout
    select(3'b001);
    repeat (10) @(negedge clk);
    chk("tout_still_busy", 32'(busy), 32'd1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (abort_pulse === 1'b1) seen = 1;
    end
    chk("tout_abort_seen", 32'(seen), 32'd1);
    chk("tout_slot_held", 32'(slot(0)), 32'd5);

    // asynchronous reset mid-entry
    select(3'b100);
    key(8'h16);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_values", 32'(chan_values), 32'd0);
    chk("arst_count", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
